// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle CPU control unit.
// Sequences FETCH / DECODE / EXECUTE / MEM / WRITEBACK / INT / ERR over the
// instruction, data and port buses. Supports NUM_IRQ prioritised level
// interrupts (IRQ0 highest) gated by a global enable and an in-service flag,
// and a bus-ack timeout that raises a one-cycle bus error.
// Optional build macro CTRL_PERF_CNT_EN adds instret_o, a retired-instruction
// counter.
module cpu_ctrl_fsm #(
  parameter int NUM_IRQ = 4,
  parameter int TIMEOUT = 15,
  localparam int VEC_W  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               inst_ack_i,
  input  logic               data_ack_i,
  input  logic               port_ack_i,
  input  logic [6:0]         op_i,
  input  logic [2:0]         func_i,
  output logic               stb_o,
  output logic               cyc_o,
  output logic               pc_en_o,
  output logic               data_stb_o,
  output logic               data_cyc_o,
  output logic               data_we_o,
  output logic               port_we_o,
  output logic               reg_wrt_o,
  output logic               alu_en_o,
  output logic [3:0]         alu_op_o,
  output logic               op2_c_o,
  output logic               reti_o,
  output logic               int_ack_o,
  output logic [VEC_W-1:0]   int_vec_o,
  output logic               bus_err_o,
  output logic [2:0]         state_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]        instret_o
`endif
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_DECODE = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM = 3'd3,
    S_WRITEBACK = 3'd4,
    S_INT = 3'd5,
    S_ERR = 3'd6
  } state_t;

  // Last wait-counter value before a missing ack becomes a bus error.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_next;
  logic               r_ie;
  logic               r_in_isr;
  logic [7:0]         r_wait;
  logic [VEC_W-1:0]   r_vec;
  logic [VEC_W-1:0]   w_vec;
  logic [3:0]         w_alu_op;

  // Instruction class decode from the IR opcode.
  logic w_alu_imm, w_mem, w_shift, w_alu_reg, w_misc, w_exec;
  assign w_alu_imm = ~op_i[6];
  assign w_mem     = (op_i[6:5] == 2'b10);
  assign w_shift   = (op_i[6:4] == 3'b110);
  assign w_alu_reg = (op_i[6:3] == 4'b1110);
  assign w_misc    = (op_i == 7'b1111110);
  assign w_exec    = w_alu_imm | w_mem | w_shift | w_alu_reg;

  logic w_reti, w_ei, w_di, w_wait;
  assign w_reti = w_misc & (func_i == 3'b001);
  assign w_ei   = w_misc & (func_i == 3'b010);
  assign w_di   = w_misc & (func_i == 3'b011);
  assign w_wait = w_misc & ((func_i == 3'b100) | (func_i == 3'b101));

  // Memory sub-operation; port ops (in/out) handshake on port_ack_i.
  logic w_ld, w_st, w_in, w_out, w_port, w_mem_ack;
  assign w_ld      = w_mem & (func_i[2:1] == 2'b00);
  assign w_st      = w_mem & (func_i[2:1] == 2'b01);
  assign w_in      = w_mem & (func_i[2:1] == 2'b10);
  assign w_out     = w_mem & (func_i[2:1] == 2'b11);
  assign w_port    = w_in | w_out;
  assign w_mem_ack = w_port ? port_ack_i : data_ack_i;

  logic [NUM_IRQ-1:0] w_irq_m;
  logic               w_take_int;
  logic               w_to;
  assign w_irq_m    = irq_i & {NUM_IRQ{r_ie}};
  assign w_take_int = ~r_in_isr & (|w_irq_m);
  assign w_to       = (r_wait == TO_LAST);

  // Lowest-numbered pending (enabled) request wins the vector.
  always_comb begin
    w_vec = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_irq_m[i]) w_vec = VEC_W'(i);
    end
  end

  // ALU operation: reg/imm forms pass func except the two reserved codes.
  always_comb begin
    w_alu_op = 4'b0000;
    if (w_alu_imm | w_alu_reg) begin
      if ((func_i != 3'b011) && (func_i != 3'b100)) w_alu_op = {1'b0, func_i};
    end else if (w_shift) begin
      w_alu_op = {2'b10, func_i[1:0]};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Next-state logic; an ack in the expiry cycle takes priority over timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (inst_ack_i) w_next = S_DECODE;
        else if (w_to)  w_next = S_ERR;
      end
      S_DECODE: begin
        if (w_exec)      w_next = S_EXECUTE;
        else if (w_wait) w_next = w_take_int ? S_INT : S_DECODE;
        else             w_next = w_take_int ? S_INT : S_FETCH;
      end
      S_EXECUTE:   w_next = w_mem ? S_MEM : S_WRITEBACK;
      S_MEM: begin
        if (w_mem_ack) begin
          if (w_ld | w_in) w_next = S_WRITEBACK;
          else             w_next = w_take_int ? S_INT : S_FETCH;
        end else if (w_to) begin
          w_next = S_ERR;
        end
      end
      S_WRITEBACK: w_next = w_take_int ? S_INT : S_FETCH;
      default:     w_next = S_FETCH;
    endcase
  end

  // Interrupt enable, in-service flag, vector latch and ack wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ie     <= 1'b0;
      r_in_isr <= 1'b0;
      r_wait   <= 8'd0;
      r_vec    <= '0;
    end else begin
      if (w_next != r_state)                          r_wait <= 8'd0;
      else if ((r_state == S_FETCH) || (r_state == S_MEM)) r_wait <= r_wait + 8'd1;
      if (r_state == S_DECODE) begin
        if (w_ei)      r_ie <= 1'b1;
        else if (w_di) r_ie <= 1'b0;
        if (w_reti)    r_in_isr <= 1'b0;
      end
      if ((w_next == S_INT) && (r_state != S_INT)) begin
        r_in_isr <= 1'b1;
        r_vec    <= w_vec;
      end
    end
  end

  // Moore/Mealy outputs per state; everything defaults low.
  always_comb begin
    stb_o      = 1'b0;
    cyc_o      = 1'b0;
    pc_en_o    = 1'b0;
    data_stb_o = 1'b0;
    data_cyc_o = 1'b0;
    data_we_o  = 1'b0;
    port_we_o  = 1'b0;
    reg_wrt_o  = 1'b0;
    alu_en_o   = 1'b0;
    alu_op_o   = 4'b0000;
    op2_c_o    = 1'b0;
    reti_o     = 1'b0;
    int_ack_o  = 1'b0;
    bus_err_o  = 1'b0;
    case (r_state)
      S_FETCH: begin
        stb_o   = 1'b1;
        cyc_o   = 1'b1;
        pc_en_o = inst_ack_i;
      end
      S_DECODE: begin
        alu_op_o = w_alu_op;
        op2_c_o  = w_alu_reg;
        reti_o   = w_reti;
      end
      S_EXECUTE: begin
        alu_op_o  = w_alu_op;
        op2_c_o   = w_alu_reg;
        alu_en_o  = ~w_mem;
        port_we_o = w_out;
      end
      S_MEM: begin
        data_stb_o = w_ld | w_st;
        data_cyc_o = w_ld | w_st;
        data_we_o  = w_st;
        port_we_o  = w_out;
      end
      S_WRITEBACK: begin
        alu_op_o  = w_alu_op;
        op2_c_o   = w_alu_reg;
        reg_wrt_o = 1'b1;
      end
      S_INT:   int_ack_o = 1'b1;
      S_ERR:   bus_err_o = 1'b1;
      default: ;
    endcase
  end

  assign state_o   = r_state;
  assign int_vec_o = r_vec;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] r_instret;
  logic        w_retire;
  assign w_retire = ((r_state == S_DECODE) && !w_exec && (w_next != S_DECODE)) ||
                    (r_state == S_WRITEBACK) ||
                    ((r_state == S_MEM) && w_mem_ack && (w_st | w_out));

  // Retired-instruction counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst)           r_instret <= 32'd0;
    else if (w_retire) r_instret <= r_instret + 32'd1;
  end

  assign instret_o = r_instret;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm (default build, NUM_IRQ=4, TIMEOUT=15).
// The driver pushes the hand-derived expected observation for every cycle it
// drives; a monitor pops and compares on the falling edge.
module tb_cpu_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq_i;
  logic       inst_ack_i, data_ack_i, port_ack_i;
  logic [6:0] op_i;
  logic [2:0] func_i;
  logic       stb_o, cyc_o, pc_en_o, data_stb_o, data_cyc_o, data_we_o;
  logic       port_we_o, reg_wrt_o, alu_en_o, op2_c_o, reti_o, int_ack_o;
  logic       bus_err_o;
  logic [3:0] alu_op_o;
  logic [1:0] int_vec_o;
  logic [2:0] state_o;

  cpu_ctrl_fsm #(.NUM_IRQ(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .irq_i(irq_i),
    .inst_ack_i(inst_ack_i), .data_ack_i(data_ack_i), .port_ack_i(port_ack_i),
    .op_i(op_i), .func_i(func_i),
    .stb_o(stb_o), .cyc_o(cyc_o), .pc_en_o(pc_en_o),
    .data_stb_o(data_stb_o), .data_cyc_o(data_cyc_o), .data_we_o(data_we_o),
    .port_we_o(port_we_o), .reg_wrt_o(reg_wrt_o), .alu_en_o(alu_en_o),
    .alu_op_o(alu_op_o), .op2_c_o(op2_c_o), .reti_o(reti_o),
    .int_ack_o(int_ack_o), .int_vec_o(int_vec_o), .bus_err_o(bus_err_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3,
                         S_W = 3'd4, S_I = 3'd5, S_X = 3'd6;
  // Flag bits: stb cyc pc_en dstb dcyc dwe pwe regw alu_en op2 reti iack berr
  localparam logic [12:0] F_FB   = 13'h1800;
  localparam logic [12:0] F_PC   = 13'h0400;
  localparam logic [12:0] F_DB   = 13'h0300;
  localparam logic [12:0] F_DWE  = 13'h0080;
  localparam logic [12:0] F_PWE  = 13'h0040;
  localparam logic [12:0] F_RW   = 13'h0020;
  localparam logic [12:0] F_ALU  = 13'h0010;
  localparam logic [12:0] F_OP2  = 13'h0008;
  localparam logic [12:0] F_RETI = 13'h0004;
  localparam logic [12:0] F_IACK = 13'h0002;
  localparam logic [12:0] F_BERR = 13'h0001;
  localparam logic [12:0] F_NONE = 13'h0000;

  localparam logic [6:0] OP_ALU = 7'b0000000, OP_MEM = 7'b1000000,
                         OP_SHF = 7'b1100000, OP_ALR = 7'b1110000,
                         OP_BR  = 7'b1111100, OP_MSC = 7'b1111110;

  logic [21:0] exp_q[$];
  logic [1:0]  cur_vec;
  int          n_checks = 0;
  int          n_fail = 0;

  // Queue the expected observation for the current cycle, advance one clock.
  task automatic step(input logic [2:0] st, input logic [3:0] aop,
                      input logic [12:0] fl);
    exp_q.push_back({st, aop, cur_vec, fl});
    @(posedge clk);
    #1;
  endtask

  // FETCH cycle with immediate instruction ack, presenting op/func.
  task automatic instr(input logic [6:0] op, input logic [2:0] fn);
    op_i = op;
    func_i = fn;
    inst_ack_i = 1'b1;
    step(S_F, 4'h0, F_FB | F_PC);
    inst_ack_i = 1'b0;
  endtask

  // Monitor: compares every observation the driver has queued.
  always @(negedge clk) begin
    logic [21:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state_o, alu_op_o, int_vec_o, stb_o, cyc_o, pc_en_o, data_stb_o,
           data_cyc_o, data_we_o, port_we_o, reg_wrt_o, alu_en_o, op2_c_o,
           reti_o, int_ack_o, bus_err_o};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL obs t=%0t got=%h exp=%h (state got %0d exp %0d)",
                 $time, a, e, a[21:19], e[21:19]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; irq_i = 4'b0; inst_ack_i = 1'b0; data_ack_i = 1'b0;
    port_ack_i = 1'b0; op_i = 7'b0; func_i = 3'b0; cur_vec = 2'd0;
    @(posedge clk);
    #1;
    step(S_F, 4'h0, F_FB);                 // reset state
    rst = 1'b0;

    // ALU immediate, func 001
    instr(OP_ALU, 3'b001);
    step(S_D, 4'h1, F_NONE); step(S_E, 4'h1, F_ALU); step(S_W, 4'h1, F_RW);

    // Load, data ack in third MEM cycle
    instr(OP_MEM, 3'b000);
    step(S_D, 4'h0, F_NONE); step(S_E, 4'h0, F_NONE);
    step(S_M, 4'h0, F_DB); step(S_M, 4'h0, F_DB);
    data_ack_i = 1'b1; step(S_M, 4'h0, F_DB); data_ack_i = 1'b0;
    step(S_W, 4'h0, F_RW);

    // Store, immediate ack
    instr(OP_MEM, 3'b010);
    step(S_D, 4'h0, F_NONE); step(S_E, 4'h0, F_NONE);
    data_ack_i = 1'b1; step(S_M, 4'h0, F_DB | F_DWE); data_ack_i = 1'b0;

    // Port out, immediate ack
    instr(OP_MEM, 3'b110);
    step(S_D, 4'h0, F_NONE); step(S_E, 4'h0, F_PWE);
    port_ack_i = 1'b1; step(S_M, 4'h0, F_PWE); port_ack_i = 1'b0;

    // Port in, ack on second MEM cycle; data ack must be ignored
    instr(OP_MEM, 3'b100);
    step(S_D, 4'h0, F_NONE); step(S_E, 4'h0, F_NONE);
    data_ack_i = 1'b1; step(S_M, 4'h0, F_NONE); data_ack_i = 1'b0;
    port_ack_i = 1'b1; step(S_M, 4'h0, F_NONE); port_ack_i = 1'b0;
    step(S_W, 4'h0, F_RW);

    // Shift func 111 -> alu_op 1011
    instr(OP_SHF, 3'b111);
    step(S_D, 4'hB, F_NONE); step(S_E, 4'hB, F_ALU); step(S_W, 4'hB, F_RW);

    // ALU immediate func 011 -> alu_op 0000
    instr(OP_ALU, 3'b011);
    step(S_D, 4'h0, F_NONE); step(S_E, 4'h0, F_ALU); step(S_W, 4'h0, F_RW);

    // ei, then ALU reg with irq 0110 raised in WRITEBACK
    instr(OP_MSC, 3'b010); step(S_D, 4'h0, F_NONE);
    instr(OP_ALR, 3'b110);
    step(S_D, 4'h6, F_OP2); step(S_E, 4'h6, F_ALU | F_OP2);
    irq_i = 4'b0110; step(S_W, 4'h6, F_RW | F_OP2);
    cur_vec = 2'd1; step(S_I, 4'h0, F_IACK);

    // In service: pending irq ignored
    instr(OP_ALU, 3'b000);
    step(S_D, 4'h0, F_NONE); step(S_E, 4'h0, F_ALU); step(S_W, 4'h0, F_RW);

    // reti (uses old in_isr, so no entry here)
    instr(OP_MSC, 3'b001); step(S_D, 4'h0, F_RETI);

    // Branch now enters INT; priority picks IRQ2
    instr(OP_BR, 3'b000);
    irq_i = 4'b0100; step(S_D, 4'h0, F_NONE);
    cur_vec = 2'd2; step(S_I, 4'h0, F_IACK);
    irq_i = 4'b0000;
    instr(OP_MSC, 3'b001); step(S_D, 4'h0, F_RETI);

    // wait holds DECODE for 20 cycles, then IRQ3
    instr(OP_MSC, 3'b100);
    repeat (20) step(S_D, 4'h0, F_NONE);
    irq_i = 4'b1000; step(S_D, 4'h0, F_NONE);
    cur_vec = 2'd3; step(S_I, 4'h0, F_IACK);
    irq_i = 4'b0000;
    instr(OP_MSC, 3'b001); step(S_D, 4'h0, F_RETI);

    // standby then IRQ2+3 -> vector 2
    instr(OP_MSC, 3'b101);
    repeat (3) step(S_D, 4'h0, F_NONE);
    irq_i = 4'b1100; step(S_D, 4'h0, F_NONE);
    cur_vec = 2'd2; step(S_I, 4'h0, F_IACK);
    irq_i = 4'b0000;
    instr(OP_MSC, 3'b001); step(S_D, 4'h0, F_RETI);

    // di: pending irq no longer taken
    instr(OP_MSC, 3'b011); step(S_D, 4'h0, F_NONE);
    irq_i = 4'b0001;
    instr(OP_BR, 3'b000); step(S_D, 4'h0, F_NONE);
    irq_i = 4'b0000;

    // Instruction bus timeout
    repeat (15) step(S_F, 4'h0, F_FB);
    step(S_X, 4'h0, F_BERR);
    // Ack in the expiry cycle wins
    op_i = OP_BR; func_i = 3'b000;
    repeat (14) step(S_F, 4'h0, F_FB);
    inst_ack_i = 1'b1; step(S_F, 4'h0, F_FB | F_PC); inst_ack_i = 1'b0;
    step(S_D, 4'h0, F_NONE);

    // Data bus timeout in MEM
    instr(OP_MEM, 3'b000);
    step(S_D, 4'h0, F_NONE); step(S_E, 4'h0, F_NONE);
    repeat (15) step(S_M, 4'h0, F_DB);
    step(S_X, 4'h0, F_BERR);

    // ei, then reset in the middle of a load
    instr(OP_MSC, 3'b010); step(S_D, 4'h0, F_NONE);
    instr(OP_MEM, 3'b000);
    step(S_D, 4'h0, F_NONE); step(S_E, 4'h0, F_NONE);
    step(S_M, 4'h0, F_DB);
    rst = 1'b1; step(S_M, 4'h0, F_DB);
    rst = 1'b0; cur_vec = 2'd0;
    step(S_F, 4'h0, F_FB);
    // ie cleared by reset: branch with irq pending returns to FETCH
    irq_i = 4'b0001;
    instr(OP_BR, 3'b000); step(S_D, 4'h0, F_NONE);
    step(S_F, 4'h0, F_FB);
    irq_i = 4'b0000;

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d observations left unchecked, required 0",
               exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
